// File: rtl/inverse_clarke.sv
// Inverse Clarke transform (alpha, beta) -> (a, b, c), amplitude-invariant form.
// Three-state start/done handshake: capture, multiply by sqrt3/2 in Q-format, combine and saturate.
module inverse_clarke #(
  parameter int D_WIDTH = 32,
  parameter int Q_BITS  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [D_WIDTH-1:0] alpha,
  input  logic signed [D_WIDTH-1:0] beta,
  input  logic                      start,
  output logic signed [D_WIDTH-1:0] a,
  output logic signed [D_WIDTH-1:0] b,
  output logic signed [D_WIDTH-1:0] c,
  output logic                      busy,
  output logic                      done
);

  localparam int PW    = D_WIDTH + Q_BITS + 1;
  localparam int EW    = D_WIDTH + 2;
  localparam int K_INT = int'(0.8660254038 * (2.0 ** Q_BITS));
  localparam logic signed [PW-1:0] K_W   = PW'(K_INT);
  localparam logic signed [EW-1:0] MAX_E = {3'b000, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_E = {3'b111, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, COMB} state_t;

  state_t state, state_nxt;

  logic signed [D_WIDTH-1:0] alpha_r, beta_r;
  logic signed [PW-1:0]      prod_r;
  logic signed [PW-1:0]      beta_w;
  logic signed [D_WIDTH-1:0] half;
  logic signed [D_WIDTH:0]   s;
  logic signed [EW-1:0]      half_e, s_e, b_ext, c_ext;

  function automatic logic signed [D_WIDTH-1:0] saturate(input logic signed [EW-1:0] x);
    if (x > MAX_E)      return MAX_E[D_WIDTH-1:0];
    else if (x < MIN_E) return MIN_E[D_WIDTH-1:0];
    else                return x[D_WIDTH-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MULT;
      MULT:    state_nxt = COMB;
      COMB:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // beta is sign-extended to the full product width so the multiply never truncates.
  assign beta_w = {{(Q_BITS+1){beta_r[D_WIDTH-1]}}, beta_r};
  assign half   = alpha_r >>> 1;
  assign s      = prod_r[PW-1:Q_BITS];
  assign half_e = {{2{half[D_WIDTH-1]}}, half};
  assign s_e    = {s[D_WIDTH], s};
  assign b_ext  = s_e - half_e;
  assign c_ext  = '0 - half_e - s_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      alpha_r <= '0;
      beta_r  <= '0;
      prod_r  <= '0;
      a       <= '0;
      b       <= '0;
      c       <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == COMB);
      case (state)
        IDLE: if (start) begin
          alpha_r <= alpha;
          beta_r  <= beta;
        end
        MULT: prod_r <= beta_w * K_W;
        COMB: begin
          a <= alpha_r;
          b <= saturate(b_ext);
          c <= saturate(c_ext);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_clarke.sv
// Directed bench for inverse_clarke: reset, single transforms, saturation, back-to-back, mid-flight reset.
module tb_inverse_clarke;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [31:0] alpha, beta;
  logic               start;
  logic signed [31:0] a, b, c;
  logic               busy, done;

  int checks = 0;
  int errors = 0;

  inverse_clarke #(.D_WIDTH(32), .Q_BITS(10)) dut (
    .clk(clk), .reset(reset), .alpha(alpha), .beta(beta), .start(start),
    .a(a), .b(b), .c(c), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs driven and outputs sampled on the falling edge.
  task automatic run_vec(input string name, input logic signed [31:0] al, input logic signed [31:0] be,
                         input logic signed [31:0] ea, input logic signed [31:0] eb,
                         input logic signed [31:0] ec);
    @(negedge clk);
    alpha = al; beta = be; start = 1'b1;
    @(negedge clk);
    start = 1'b0; alpha = 32'sd12345; beta = -32'sd999;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL %s cyc1 busy=%b done=%b required busy=1 done=0", name, busy, done); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL %s cyc2 busy=%b done=%b required busy=1 done=0", name, busy, done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL %s done_pulse busy=%b done=%b required busy=0 done=1", name, busy, done); end
    checks++; if (a !== ea) begin errors++; $display("FAIL %s a got %0d required %0d", name, a, ea); end
    checks++; if (b !== eb) begin errors++; $display("FAIL %s b got %0d required %0d", name, b, eb); end
    checks++; if (c !== ec) begin errors++; $display("FAIL %s c got %0d required %0d", name, c, ec); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_drop got %b required 0", name, done); end
    checks++; if (a !== ea || b !== eb || c !== ec) begin errors++; $display("FAIL %s hold got %0d %0d %0d required %0d %0d %0d", name, a, b, c, ea, eb, ec); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; alpha = 32'sd77; beta = 32'sd88;
    #3;
    checks++; if (a !== 0 || b !== 0 || c !== 0 || done !== 0 || busy !== 0) begin errors++; $display("FAIL reset_async got a=%0d b=%0d c=%0d done=%b busy=%b required all 0", a, b, c, done, busy); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (a !== 0 || b !== 0 || c !== 0 || done !== 0 || busy !== 0) begin errors++; $display("FAIL reset_idle cyc%0d got a=%0d b=%0d c=%0d done=%b busy=%b required all 0", i, a, b, c, done, busy); end
    end
  endtask

  task automatic test_basic();
    run_vec("alpha_only", 32'sd1024, 32'sd0, 32'sd1024, -32'sd512, -32'sd512);
    run_vec("beta_only", 32'sd0, 32'sd1024, 32'sd0, 32'sd887, -32'sd887);
    run_vec("neg_odd_alpha", -32'sd3, 32'sd0, -32'sd3, 32'sd2, 32'sd2);
    run_vec("neg_beta_floor", 32'sd1, -32'sd1, 32'sd1, -32'sd1, 32'sd1);
  endtask

  task automatic test_saturation();
    run_vec("sat_pos", 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, -32'sd786431999);
    run_vec("sat_neg", 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'sd786432001);
  endtask

  task automatic test_back_to_back();
    logic signed [31:0] va [13];
    logic signed [31:0] vb [13];
    logic signed [31:0] ea [13];
    logic signed [31:0] eb [13];
    logic signed [31:0] ec [13];
    for (int k = 0; k < 13; k++) begin va[k] = 32'sd7777 + k; vb[k] = -32'sd5555 - k; end
    va[0] = 32'sd1024; vb[0] = 32'sd0;    ea[0] = 32'sd1024; eb[0] = -32'sd512; ec[0] = -32'sd512;
    va[3] = 32'sd0;    vb[3] = 32'sd1024; ea[3] = 32'sd0;    eb[3] = 32'sd887;  ec[3] = -32'sd887;
    va[6] = -32'sd3;   vb[6] = 32'sd0;    ea[6] = -32'sd3;   eb[6] = 32'sd2;    ec[6] = 32'sd2;
    va[9] = 32'sd100;  vb[9] = -32'sd1;   ea[9] = 32'sd100;  eb[9] = -32'sd51;  ec[9] = -32'sd49;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++; if (done !== ((k % 3) == 0)) begin errors++; $display("FAIL b2b done cyc%0d got %b required %b", k, done, (k % 3) == 0); end
        if ((k % 3) == 0) begin
          checks++; if (a !== ea[k-3] || b !== eb[k-3] || c !== ec[k-3]) begin errors++; $display("FAIL b2b result%0d got %0d %0d %0d required %0d %0d %0d", k-3, a, b, c, ea[k-3], eb[k-3], ec[k-3]); end
        end
      end
      alpha = va[k]; beta = vb[k]; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    bit saw_done = 0;
    @(negedge clk);
    alpha = 32'sd500; beta = 32'sd500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst in_mult busy got %b required 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (a !== 0 || b !== 0 || c !== 0 || busy !== 0 || done !== 0) begin errors++; $display("FAIL midrst clear got a=%0d b=%0d c=%0d busy=%b done=%b required all 0", a, b, c, busy, done); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++; if (saw_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst no_done saw_done=%b busy=%b required 0 0", saw_done, busy); end
    run_vec("after_reset", 32'sd0, 32'sd1024, 32'sd0, 32'sd887, -32'sd887);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
